uriscv_muldiv_param: RTL and testbench
======================================

URISCV_MULDIV_PARAM -- requirements
Module: uriscv_muldiv_param

Interface
REQ-001 Parameter N, default 16: operand/result width in bits, at least 4; RV32M semantics scaled to N.
REQ-002 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_i  in  1  reset; synchronous, active-low.
REQ-004 valid_i  in  1  operation request, sampled each rising edge.
REQ-005 inst_mul_i, inst_mulh_i, inst_mulhsu_i, inst_mulhu_i  in  1 each  multiply opcode selects.
REQ-006 inst_div_i, inst_divu_i, inst_rem_i, inst_remu_i  in  1 each  divide/remainder opcode selects.
REQ-007 operand_ra_i, operand_rb_i  in  N  dividend/multiplicand (ra) and divisor/multiplier (rb).
REQ-008 stall_o  out  1  block busy; no new request is accepted.
REQ-009 ready_o  out  1  one-cycle pulse: result_o is valid.
REQ-010 result_o  out  N  result of the last completed operation.

Function
REQ-011 Accept: valid_i=1, exactly one inst_* bit set, stall_o=0; operands and opcode are captured at that edge (cycle T).
REQ-012 While stall_o=1, valid_i is ignored. When valid_i=0, all inst_* bits are 0.
REQ-013 MUL returns product[N-1:0]; operand signedness does not affect this result.
REQ-014 MULH returns the high half of signed(ra) x signed(rb).
REQ-015 MULHSU returns the high half of signed(ra) x unsigned(rb).
REQ-016 MULHU returns the high half of unsigned(ra) x unsigned(rb).
REQ-017 All multiply variants compute a 2N-bit product from (N+1)-bit sign/zero-extended operands.
REQ-018 Multiply latency: ready_o=1 at cycle T+2. stall_o=1 during cycle T+1 only.
REQ-019 DIV/DIVU return the quotient. REM/REMU return the remainder.
REQ-020 Signed division truncates toward zero; the remainder takes the sign of the dividend.
REQ-021 Divide by zero (any variant): quotient = all-ones; remainder = ra.
REQ-022 Signed overflow (ra = 1 followed by zeros, rb = all-ones): DIV = ra; REM = 0.
REQ-023 Divide implementation: iterative radix-2 restoring on magnitudes, one quotient bit per cycle, sign correction applied at the end.
REQ-024 Divide states: IDLE -> DIV_RUN (N iterations) -> DONE -> IDLE.
REQ-025 Divide latency: ready_o=1 at cycle T+N+1, independent of the operand values, including the corner cases in REQ-021/REQ-022.
REQ-026 For divides, stall_o=1 from T+1 through T+N; stall_o=0 in the ready_o cycle.
REQ-027 result_o updates only in the ready_o cycle and holds its value until the next completion.
REQ-028 ready_o never asserts without a prior accepted request; one ready_o pulse per accepted request.
REQ-029 A request arriving in the ready_o cycle is accepted normally (back-to-back operation).
REQ-030 Operand inputs may change after the accept edge without affecting the result.

Reset
REQ-031 rst_i=0 at an edge: state IDLE, stall_o=0, ready_o=0, result_o=0; any in-flight operation is aborted and produces no ready_o.
REQ-032 A request presented in the same cycle as rst_i=0 is discarded; the first accept is possible at the first edge with rst_i=1.

Structure
REQ-033 A shared package holds the op-select enum (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) and the divide state enum.
REQ-034 The iterative divider is one sub-module, uriscv_div_iter, with start, operands, signed flag, busy, done, quotient and remainder ports.
REQ-035 The multiply path and the output muxing stay in the top level.

Verification (N=16)
REQ-036 MUL 0xFFFF x 0xFFFF -> 0x0001 at T+2; MULHU on the same operands -> 0xFFFE.
REQ-037 MULH 0x8000 x 0x8000 -> 0x4000; MULHSU 0xFFFF x 0xFFFF -> 0xFFFF; each at T+2.
REQ-038 DIV 0xFFF9 / 0x0002 -> 0xFFFD; REM on the same operands -> 0xFFFF; each at T+17, with stall_o high T+1..T+16.
REQ-039 DIVU 0x1234 / 0 -> 0xFFFF; REMU 0x1234 / 0 -> 0x1234; DIV 0x8000 / 0xFFFF -> 0x8000; REM on the same operands -> 0x0000.
REQ-040 Start DIVU, drive rst_i=0 at T+5 -> no ready_o; outputs zero; a MUL 3 x 5 issued after reset release -> 0x000F at accept+2.

Source files
------------

// File: rtl/uriscv_muldiv_param_pkg.sv
// Shared types and opcode helpers for the parameterised RV32M-style multiply/divide block.
package uriscv_muldiv_param_pkg;

    typedef enum logic [2:0] {
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
        OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } op_e;

    typedef enum logic [1:0] {
        IDLE, DIV_RUN, DONE
    } div_state_e;

    // Select vector bit order matches the op_e encoding.
    function automatic op_e decode_op(input logic [7:0] sel);
        op_e op;
        op = OP_MUL;
        for (int i = 0; i < 8; i++) begin
            if (sel[i]) op = op_e'(i[2:0]);
        end
        return op;
    endfunction

    function automatic logic is_onehot8(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

    function automatic logic is_div_op(input op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_signed_div(input op_e op);
        return op inside {OP_DIV, OP_REM};
    endfunction

    function automatic logic is_quotient_op(input op_e op);
        return op inside {OP_DIV, OP_DIVU};
    endfunction

endpackage

// File: rtl/uriscv_muldiv_param_if.sv
// Request/response bundle of the multiply/divide block.
interface uriscv_muldiv_param_if #(parameter int N = 16);
    logic         valid_i;
    logic         inst_mul_i;
    logic         inst_mulh_i;
    logic         inst_mulhsu_i;
    logic         inst_mulhu_i;
    logic         inst_div_i;
    logic         inst_divu_i;
    logic         inst_rem_i;
    logic         inst_remu_i;
    logic [N-1:0] operand_ra_i;
    logic [N-1:0] operand_rb_i;
    logic         stall_o;
    logic         ready_o;
    logic [N-1:0] result_o;

    modport master (
        output valid_i, inst_mul_i, inst_mulh_i, inst_mulhsu_i, inst_mulhu_i,
               inst_div_i, inst_divu_i, inst_rem_i, inst_remu_i,
               operand_ra_i, operand_rb_i,
        input  stall_o, ready_o, result_o
    );

    modport slave (
        input  valid_i, inst_mul_i, inst_mulh_i, inst_mulhsu_i, inst_mulhu_i,
               inst_div_i, inst_divu_i, inst_rem_i, inst_remu_i,
               operand_ra_i, operand_rb_i,
        output stall_o, ready_o, result_o
    );
endinterface

// File: rtl/uriscv_div_iter.sv
// Radix-2 restoring divider on operand magnitudes: one quotient bit per cycle,
// sign and divide-by-zero fixups applied combinationally in the DONE state.
module uriscv_div_iter
    import uriscv_muldiv_param_pkg::*;
#(
    parameter int N = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start,
    input  logic         is_signed,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder
);
    localparam int CW = $clog2(N);

    div_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  quo_p0, rem_p0, dvs_p0;
    logic          neg_q_p0, neg_r_p0, zero_p0;
    logic          a_neg, b_neg;
    logic [N:0]    shifted, diff;

    assign a_neg   = is_signed & dividend[N-1];
    assign b_neg   = is_signed & divisor[N-1];
    assign shifted = {rem_p0, quo_p0[N-1]};
    assign diff    = shifted - {1'b0, dvs_p0};
    assign busy    = (state_q == DIV_RUN);
    assign done    = (state_q == DONE);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DIV_RUN;
                    cnt_d   = '0;
                end
            end
            DIV_RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) state_d = DONE;
            end
            DONE: begin
                state_d = start ? DIV_RUN : IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Iteration stage: quotient bits shift in from the right as dividend bits shift out.
    always_ff @(posedge clk_i) begin
        if (start && !busy) begin
            quo_p0   <= a_neg ? -dividend : dividend;
            dvs_p0   <= b_neg ? -divisor : divisor;
            rem_p0   <= '0;
            zero_p0  <= (divisor == '0);
            neg_q_p0 <= a_neg ^ b_neg;
            neg_r_p0 <= a_neg;
        end else if (state_q == DIV_RUN) begin
            if (!diff[N]) begin
                rem_p0 <= diff[N-1:0];
                quo_p0 <= {quo_p0[N-2:0], 1'b1};
            end else begin
                rem_p0 <= shifted[N-1:0];
                quo_p0 <= {quo_p0[N-2:0], 1'b0};
            end
        end
    end

    // With a zero divisor the remainder magnitude is |ra|, so the usual sign fixup yields ra.
    assign quotient  = zero_p0 ? '1 : (neg_q_p0 ? -quo_p0 : quo_p0);
    assign remainder = neg_r_p0 ? -rem_p0 : rem_p0;

endmodule

// File: rtl/uriscv_muldiv_param.sv
// Multiply/divide unit: two-cycle multiply pipeline plus an iterative divider,
// with a single result register shared by both paths.
module uriscv_muldiv_param
    import uriscv_muldiv_param_pkg::*;
#(
    parameter int N = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    uriscv_muldiv_param_if.slave   bus
);
    logic [7:0]              inst_vec;
    op_e                     op_dec, op_p0;
    logic                    stall, accept, div_start;
    logic                    vld_p0, vld_p1;
    logic [N-1:0]            a_p0, b_p0, res_q;
    logic signed [N:0]       a_ext, b_ext;
    logic signed [2*N+1:0]   prod_p0;
    logic [1:0]              prod_unused;
    logic [N-1:0]            mul_res_p0, div_res;
    logic                    div_busy, div_done;
    logic [N-1:0]            div_quo, div_rem;

    function automatic logic signed [N:0] ext_operand(input logic [N-1:0] v, input logic sgn);
        return $signed({sgn & v[N-1], v});
    endfunction

    assign inst_vec  = {bus.inst_remu_i, bus.inst_rem_i, bus.inst_divu_i, bus.inst_div_i,
                        bus.inst_mulhu_i, bus.inst_mulhsu_i, bus.inst_mulh_i, bus.inst_mul_i};
    assign op_dec    = decode_op(inst_vec);
    assign stall     = vld_p0 | div_busy;
    assign accept    = bus.valid_i & ~stall & is_onehot8(inst_vec);
    assign div_start = accept & is_div_op(op_dec);

    // Accept stage: opcode and operands are captured here and never re-read from the bus.
    always_ff @(posedge clk_i) begin
        if (!rst_i) vld_p0 <= 1'b0;
        else        vld_p0 <= accept & ~is_div_op(op_dec);
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            a_p0  <= bus.operand_ra_i;
            b_p0  <= bus.operand_rb_i;
            op_p0 <= op_dec;
        end
    end

    assign a_ext       = ext_operand(a_p0, op_p0 inside {OP_MULH, OP_MULHSU});
    assign b_ext       = ext_operand(b_p0, op_p0 == OP_MULH);
    assign prod_p0     = $signed({{(N+1){a_ext[N]}}, a_ext}) * $signed({{(N+1){b_ext[N]}}, b_ext});
    assign prod_unused = prod_p0[2*N+1:2*N];
    assign mul_res_p0  = (op_p0 == OP_MUL) ? prod_p0[N-1:0] : prod_p0[2*N-1:N];
    assign div_res     = is_quotient_op(op_p0) ? div_quo : div_rem;

    uriscv_div_iter #(.N(N)) u_div (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start     (div_start),
        .is_signed (is_signed_div(op_dec)),
        .dividend  (bus.operand_ra_i),
        .divisor   (bus.operand_rb_i),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Result stage: the multiply lands here; a divide result is shown straight from the
    // divider in its DONE cycle and then retained here.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            vld_p1 <= 1'b0;
            res_q  <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0)        res_q <= mul_res_p0;
            else if (div_done) res_q <= div_res;
        end
    end

    assign bus.stall_o  = stall;
    assign bus.ready_o  = vld_p1 | div_done;
    assign bus.result_o = div_done ? div_res : res_q;

endmodule

// File: tb/tb_uriscv_muldiv_param.sv
// Directed bench for uriscv_muldiv_param at N=16: results, latencies, stall window, reset abort.
module tb_uriscv_muldiv_param;
    localparam int N = 16;
    localparam int MUL = 0, MULH = 1, MULHSU = 2, MULHU = 3;
    localparam int DIV = 4, DIVU = 5, REM = 6, REMU = 7;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk_i = ~clk_i;

    uriscv_muldiv_param_if #(.N(N)) bus ();

    uriscv_muldiv_param #(.N(N)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    int           n_chk = 0;
    int           n_pass = 0;
    logic [N-1:0] last_exp = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic drive(input int op, input logic [N-1:0] a, input logic [N-1:0] b);
        bus.valid_i       = 1'b1;
        bus.inst_mul_i    = (op == MUL);
        bus.inst_mulh_i   = (op == MULH);
        bus.inst_mulhsu_i = (op == MULHSU);
        bus.inst_mulhu_i  = (op == MULHU);
        bus.inst_div_i    = (op == DIV);
        bus.inst_divu_i   = (op == DIVU);
        bus.inst_rem_i    = (op == REM);
        bus.inst_remu_i   = (op == REMU);
        bus.operand_ra_i  = a;
        bus.operand_rb_i  = b;
    endtask

    // Idle bus with scrambled operands so late operand changes would show up in results.
    task automatic idle_bus();
        bus.valid_i       = 1'b0;
        bus.inst_mul_i    = 1'b0;
        bus.inst_mulh_i   = 1'b0;
        bus.inst_mulhsu_i = 1'b0;
        bus.inst_mulhu_i  = 1'b0;
        bus.inst_div_i    = 1'b0;
        bus.inst_divu_i   = 1'b0;
        bus.inst_rem_i    = 1'b0;
        bus.inst_remu_i   = 1'b0;
        bus.operand_ra_i  = N'($urandom);
        bus.operand_rb_i  = N'($urandom);
    endtask

    // Issue one op, then walk cycle by cycle to ready_o; returns in the ready cycle so the
    // next call issues back-to-back.
    task automatic run_op(input string tag, input int op, input logic [N-1:0] a,
                          input logic [N-1:0] b, input logic [N-1:0] exp);
        int lat;
        int exp_lat;
        bit stall_ok;
        exp_lat  = (op >= DIV) ? N + 1 : 2;
        stall_ok = 1'b1;
        drive(op, a, b);
        @(posedge clk_i); #1;
        idle_bus();
        lat = 1;
        check_val({tag, "_hold"}, bus.result_o, last_exp);
        while (!bus.ready_o && lat < 40) begin
            if (!bus.stall_o) stall_ok = 1'b0;
            @(posedge clk_i); #1;
            lat++;
        end
        check_val({tag, "_lat"}, lat, exp_lat);
        check_val({tag, "_stall"}, stall_ok, 1);
        check_val({tag, "_stall_rdy"}, bus.stall_o, 0);
        check_val({tag, "_res"}, bus.result_o, exp);
        last_exp = exp;
    endtask

    initial begin
        bit seen;
        idle_bus();
        drive(MUL, 16'd3, 16'd5);
        repeat (3) @(posedge clk_i);
        #1;
        check_val("rst_ready", bus.ready_o, 0);
        check_val("rst_stall", bus.stall_o, 0);
        check_val("rst_result", bus.result_o, 0);
        rst_i = 1'b1;

        run_op("mul_3x5_first", MUL, 16'd3, 16'd5, 16'h000F);
        run_op("mul_ffff", MUL, 16'hFFFF, 16'hFFFF, 16'h0001);
        run_op("mulhu_ffff", MULHU, 16'hFFFF, 16'hFFFF, 16'hFFFE);
        run_op("mulh_8000", MULH, 16'h8000, 16'h8000, 16'h4000);
        run_op("mulhsu_ffff", MULHSU, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        run_op("mulh_neg2", MULH, 16'hFFFF, 16'h0002, 16'hFFFF);
        run_op("mul_low", MUL, 16'h1234, 16'h0100, 16'h3400);
        run_op("div_m7_2", DIV, 16'hFFF9, 16'h0002, 16'hFFFD);
        run_op("rem_m7_2", REM, 16'hFFF9, 16'h0002, 16'hFFFF);
        run_op("div_7_m2", DIV, 16'h0007, 16'hFFFE, 16'hFFFD);
        run_op("rem_7_m2", REM, 16'h0007, 16'hFFFE, 16'h0001);
        run_op("rem_m7_m2", REM, 16'hFFF9, 16'hFFFE, 16'hFFFF);
        run_op("divu_big", DIVU, 16'hFFFF, 16'h0010, 16'h0FFF);
        run_op("remu_big", REMU, 16'hFFFF, 16'h0010, 16'h000F);
        run_op("divu_zero", DIVU, 16'h1234, 16'h0000, 16'hFFFF);
        run_op("remu_zero", REMU, 16'h1234, 16'h0000, 16'h1234);
        run_op("div_zero_neg", DIV, 16'h8001, 16'h0000, 16'hFFFF);
        run_op("rem_zero_neg", REM, 16'h8001, 16'h0000, 16'h8001);
        run_op("div_ovf", DIV, 16'h8000, 16'hFFFF, 16'h8000);
        run_op("rem_ovf", REM, 16'h8000, 16'hFFFF, 16'h0000);
        run_op("mul_after_div", MUL, 16'h0011, 16'h0011, 16'h0121);

        // Abort a divide in flight: reset at cycle T+5, no completion may follow.
        drive(DIVU, 16'h1234, 16'h0003);
        @(posedge clk_i); #1;
        idle_bus();
        repeat (4) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        check_val("abort_stall", bus.stall_o, 0);
        check_val("abort_ready", bus.ready_o, 0);
        check_val("abort_result", bus.result_o, 0);
        rst_i = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk_i); #1;
            if (bus.ready_o) seen = 1'b1;
        end
        check_val("abort_no_ready", seen, 0);
        last_exp = '0;
        run_op("mul_3x5_post_abort", MUL, 16'd3, 16'd5, 16'h000F);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
